// File: rtl/uart_word_link.sv
// Word UART link: WORD_W-bit words as WORD_W/8 LSB-first byte frames, FIFO per direction,
// run-time baud divisor, sticky framing/overrun errors. Even parity is enabled by UART_PARITY_EN.

module uart_word_link_fifo #(
    parameter int W  = 32,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    input  logic         rd,
    output logic [W-1:0] r_data,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          do_rd, do_wr;

    // a read frees the slot, so a write to a full FIFO is accepted alongside it
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || rd);
    assign full  = (cnt == (AW+1)'(2**AW));
    assign empty = (cnt == '0);
    assign r_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= w_data;
    end
endmodule

module uart_word_link #(
    parameter int WORD_W  = 32,
    parameter int FIFO_W  = 2,
    parameter int DIV_W   = 16,
    parameter int SB_TICK = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DIV_W-1:0]  i_divisor,
    input  logic              i_rx,
    input  logic              i_wr_uart,
    input  logic [WORD_W-1:0] i_w_data,
    input  logic              i_rd_uart,
    input  logic              i_clr_err,
    output logic              o_tx,
    output logic              o_tx_full,
    output logic              o_tx_empty,
    output logic              o_tx_done_tick,
    output logic              o_rx_empty,
    output logic [WORD_W-1:0] o_r_data,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_parity_err
);
    localparam int BYTES = WORD_W / 8;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST     = IW'(BYTES - 1);
    localparam logic [4:0]    STOP_END = 5'(SB_TICK - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [DIV_W-1:0] baud_cnt;
    logic             tick;

    // >= so a divisor lowered below the running count ticks immediately
    assign tick = (baud_cnt >= i_divisor);

    always_ff @(posedge i_clk) begin
        if (i_reset) baud_cnt <= '0;
        else         baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
    end

    // ---------------- transmit ----------------
    logic [2:0]        tx_state;
    logic [4:0]        tx_s;
    logic [2:0]        tx_n;
    logic [IW-1:0]     tx_idx;
    logic [WORD_W-1:0] tx_word, tx_word_sh, tx_head;
    logic [7:0]        tx_byte;
    logic              tx_reg, tx_pop;

    assign tx_pop     = (tx_state == S_IDLE) && !o_tx_empty;
    assign tx_word_sh = tx_word >> 8;
    assign o_tx       = tx_reg;

    uart_word_link_fifo #(.W(WORD_W), .AW(FIFO_W)) u_tx_fifo (
        .clk(i_clk), .reset(i_reset), .wr(i_wr_uart), .w_data(i_w_data),
        .rd(tx_pop), .r_data(tx_head), .full(o_tx_full), .empty(o_tx_empty)
    );

    // tx_word[7:0] holds the current byte unshifted; tx_byte is the serialiser
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state       <= S_IDLE;
            tx_s           <= '0;
            tx_n           <= '0;
            tx_idx         <= '0;
            tx_word        <= '0;
            tx_byte        <= '0;
            tx_reg         <= 1'b1;
            o_tx_done_tick <= 1'b0;
        end else begin
            o_tx_done_tick <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!o_tx_empty) begin
                        tx_word  <= tx_head;
                        tx_byte  <= tx_head[7:0];
                        tx_idx   <= '0;
                        tx_s     <= '0;
                        tx_reg   <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s     <= '0;
                        tx_n     <= '0;
                        tx_reg   <= tx_byte[0];
                        tx_state <= S_DATA;
                    end else tx_s <= tx_s + 1'b1;
                end
                S_DATA: if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s    <= '0;
                        tx_byte <= tx_byte >> 1;
                        if (tx_n == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_reg   <= ^tx_word[7:0];
                            tx_state <= S_PAR;
`else
                            tx_reg   <= 1'b1;
                            tx_state <= S_STOP;
`endif
                        end else begin
                            tx_n   <= tx_n + 1'b1;
                            tx_reg <= tx_byte[1];
                        end
                    end else tx_s <= tx_s + 1'b1;
                end
`ifdef UART_PARITY_EN
                S_PAR: if (tick) begin
                    if (tx_s == 5'd15) begin
                        tx_s     <= '0;
                        tx_reg   <= 1'b1;
                        tx_state <= S_STOP;
                    end else tx_s <= tx_s + 1'b1;
                end
`endif
                S_STOP: if (tick) begin
                    if (tx_s == STOP_END) begin
                        tx_s <= '0;
                        if (tx_idx == LAST) begin
                            o_tx_done_tick <= 1'b1;
                            tx_state       <= S_IDLE;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_word  <= tx_word_sh;
                            tx_byte  <= tx_word_sh[7:0];
                            tx_reg   <= 1'b0;
                            tx_state <= S_START;
                        end
                    end else tx_s <= tx_s + 1'b1;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- receive ----------------
    logic [2:0]        rx_state;
    logic [4:0]        rx_s;
    logic [2:0]        rx_n;
    logic [IW-1:0]     rx_idx;
    logic [7:0]        rx_byte;
    logic [WORD_W-1:0] rx_word, rx_new_word;
    logic              rx_meta, rx_sync, rx_prev;
    logic              rx_stop_end, rx_push, rx_full, frame_set, overrun_set;

    assign rx_new_word = (rx_word >> 8) | (WORD_W'(rx_byte) << (WORD_W - 8));
    assign rx_stop_end = (rx_state == S_STOP) && tick && (rx_s == STOP_END);
    assign frame_set   = rx_stop_end && !rx_sync;
    assign rx_push     = rx_stop_end && rx_sync && (rx_idx == LAST);
    assign overrun_set = rx_push && rx_full && !i_rd_uart;

    uart_word_link_fifo #(.W(WORD_W), .AW(FIFO_W)) u_rx_fifo (
        .clk(i_clk), .reset(i_reset), .wr(rx_push), .w_data(rx_new_word),
        .rd(i_rd_uart), .r_data(o_r_data), .full(rx_full), .empty(o_rx_empty)
    );

`ifdef UART_PARITY_EN
    logic par_set;
    assign par_set = (rx_state == S_PAR) && tick && (rx_s == 5'd15) && (rx_sync != ^rx_byte);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_idx   <= '0;
            rx_byte  <= '0;
            rx_word  <= '0;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                S_IDLE: if (rx_prev && !rx_sync) begin
                    rx_s     <= '0;
                    rx_state <= S_START;
                end
                S_START: if (tick) begin
                    if (rx_s == 5'd7) begin
                        rx_s     <= '0;
                        rx_n     <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else rx_s <= rx_s + 1'b1;
                end
                S_DATA: if (tick) begin
                    if (rx_s == 5'd15) begin
                        rx_s    <= '0;
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        if (rx_n == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PAR;
`else
                            rx_state <= S_STOP;
`endif
                        end else rx_n <= rx_n + 1'b1;
                    end else rx_s <= rx_s + 1'b1;
                end
`ifdef UART_PARITY_EN
                S_PAR: if (tick) begin
                    if (rx_s == 5'd15) begin
                        rx_s <= '0;
                        if (par_set) begin
                            rx_idx   <= '0;
                            rx_state <= S_IDLE;
                        end else rx_state <= S_STOP;
                    end else rx_s <= rx_s + 1'b1;
                end
`endif
                S_STOP: if (tick) begin
                    if (rx_s == STOP_END) begin
                        rx_s     <= '0;
                        rx_state <= S_IDLE;
                        if (!rx_sync || rx_idx == LAST) rx_idx <= '0;
                        else begin
                            rx_idx  <= rx_idx + 1'b1;
                            rx_word <= rx_new_word;
                        end
                    end else rx_s <= rx_s + 1'b1;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // sticky flags: a new error in the clearing clock still sets the flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= frame_set | (o_frame_err & ~i_clr_err);
            o_overrun   <= overrun_set | (o_overrun & ~i_clr_err);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) o_parity_err <= 1'b0;
        else         o_parity_err <= par_set | (o_parity_err & ~i_clr_err);
    end
`else
    assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_word_link.sv
// Scoreboard bench for uart_word_link: loopback and directly driven serial traffic.
module tb_uart_word_link;
    localparam int WORD_W = 32, FIFO_W = 2, DIV_W = 16, SB_TICK = 16;

    logic              clk = 1'b0;
    logic              reset, wr_uart, rd_uart, clr_err, loop, rx_drv, rx_line;
    logic [DIV_W-1:0]  divisor;
    logic [WORD_W-1:0] w_data, r_data;
    logic              tx, tx_full, tx_empty, tx_done_tick, rx_empty;
    logic              frame_err, overrun, parity_err;

    int total = 0, bad = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0;
    bit saw_set = 0;
    logic [WORD_W-1:0] sb[$];

    assign rx_line = loop ? tx : rx_drv;

    uart_word_link #(.WORD_W(WORD_W), .FIFO_W(FIFO_W), .DIV_W(DIV_W), .SB_TICK(SB_TICK)) dut (
        .i_clk(clk), .i_reset(reset), .i_divisor(divisor), .i_rx(rx_line),
        .i_wr_uart(wr_uart), .i_w_data(w_data), .i_rd_uart(rd_uart), .i_clr_err(clr_err),
        .o_tx(tx), .o_tx_full(tx_full), .o_tx_empty(tx_empty), .o_tx_done_tick(tx_done_tick),
        .o_rx_empty(rx_empty), .o_r_data(r_data), .o_frame_err(frame_err),
        .o_overrun(overrun), .o_parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (tx_done_tick) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_err && clr_err) saw_set = 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [WORD_W-1:0] w, input bit expect_rx);
        wr_uart = 1'b1;
        w_data  = w;
        step(1);
        wr_uart = 1'b0;
        if (expect_rx) sb.push_back(w);
    endtask

    task automatic pop_rx(input string tag);
        int t = 0;
        logic [WORD_W-1:0] exp;
        while (rx_empty && t < 4000) begin
            step(1);
            t++;
        end
        if (rx_empty) chk({tag, "_timeout"}, 1, 0);
        else if (sb.size() == 0) chk({tag, "_unexpected"}, r_data, 64'hx);
        else begin
            exp = sb.pop_front();
            chk(tag, r_data, exp);
            rd_uart = 1'b1;
            step(1);
            rd_uart = 1'b0;
        end
    endtask

    // mode 0 clean, 1 stop bit low, 2 parity bit inverted
    task automatic send_byte(input logic [7:0] b, input int mode);
        rx_drv = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            step(16);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^b) ^ (mode == 2);
        step(16);
`endif
        rx_drv = (mode != 1);
        step(SB_TICK);
        rx_drv = 1'b1;
    endtask

    task automatic decode_byte(input string tag, input logic [7:0] exp, output int start_cyc);
        int t = 0;
        logic [7:0] b;
        while (tx !== 1'b0 && t < 2000) begin
            step(1);
            t++;
        end
        start_cyc = cyc;
        step(8);
        chk({tag, "_start"}, tx, 0);
        for (int i = 0; i < 8; i++) begin
            step(16);
            b[i] = tx;
        end
        step(16);
        chk({tag, "_stop"}, tx, 1);
        chk(tag, b, exp);
    endtask

    task automatic low_run(output int len);
        int t = 0;
        while (tx !== 1'b0 && t < 3000) begin
            step(1);
            t++;
        end
        len = 0;
        while (tx === 1'b0 && len < 5000) begin
            step(1);
            len++;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int st, d0, t, r0, r1, r2, r3, r4, r5, r6;
        logic [31:0] w;
        reset = 1; loop = 1; rx_drv = 1; divisor = '0;
        wr_uart = 0; rd_uart = 0; clr_err = 0; w_data = '0;
        step(3);
        chk("rst_tx", tx, 1);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_r_data", r_data, 0);
        chk("rst_flags", {frame_err, overrun, parity_err, tx_done_tick}, 0);
        reset = 0;
        step(2);

        // loopback of one word, byte order and word timing
        d0 = done_cnt;
        w = 32'hDEADBEEF;
        push_tx(w, 1);
        chk("t1_latency_hi", tx, 1);
        step(1);
        chk("t1_latency_lo", tx, 0);
        decode_byte("t1_b0", w[7:0], st);
        for (int i = 1; i < 4; i++) decode_byte("t1_bn", w[8*i +: 8], t);
        t = 0;
        while (done_cnt == d0 && t < 200) begin step(1); t++; end
        step(20);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_word_period", done_cyc - st, 640);
        pop_rx("t1_rx");
        chk("t1_rx_empty", rx_empty, 1);

        // five words into a four-deep RX FIFO
        for (int i = 1; i <= 5; i++) push_tx(i, i <= 4);
        chk("t2_tx_full", tx_full, 1);
        t = 0;
        while (!overrun && t < 5000) begin step(1); t++; end
        chk("t2_overrun", overrun, 1);
        step(100);
        for (int i = 0; i < 4; i++) pop_rx("t2_rx");
        chk("t2_rx_empty", rx_empty, 1);
        chk("t2_tx_empty", tx_empty, 1);
        clr_err = 1; step(1); clr_err = 0;
        chk("t2_overrun_clr", overrun, 0);

        // frame error on byte 2, then a clean word
        loop = 0;
        step(5);
        w = 32'hCAFEF00D;
        send_byte(w[7:0], 0);
        send_byte(w[15:8], 0);
        send_byte(w[23:16], 1);
        step(40);
        chk("t3_frame_err", frame_err, 1);
        chk("t3_dropped", rx_empty, 1);
        w = 32'h12345678;
        sb.push_back(w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
        step(10);
        pop_rx("t3_rx");
        chk("t3_sticky", frame_err, 1);
        clr_err = 1; step(1); clr_err = 0;
        chk("t3_clr", frame_err, 0);
        clr_err = 1; saw_set = 0;
        send_byte(8'h55, 1);
        step(30);
        clr_err = 0;
        step(1);
        chk("t3_set_wins", saw_set, 1);
        chk("t3_cleared_after", frame_err, 0);
        chk("t3_no_word", rx_empty, 1);

`ifdef UART_PARITY_EN
        send_byte(8'h3C, 2);
        step(40);
        chk("t4_parity_err", parity_err, 1);
        chk("t4_dropped", rx_empty, 1);
        clr_err = 1; step(1); clr_err = 0;
        chk("t4_parity_clr", parity_err, 0);
`else
        chk("t4_parity_zero", parity_err, 0);
`endif

        // divisor 3 then 1 mid-word
        loop = 1;
        divisor = 3;
        step(5);
        push_tx(32'h01010101, 1);
        low_run(r0);
        low_run(r1);
        low_run(r2);
        divisor = 1;
        low_run(r3);
        low_run(r4);
        low_run(r5);
        low_run(r6);
        chk("t5_data_run_div3", r1, 448);
        chk("t5_start_div3", r2, 64);
        chk("t5_start_div1_b2", r4, 32);
        chk("t5_start_div1_b3", r6, 32);
        chk("t5_data_run_div1", r5, 224);
        pop_rx("t5_rx");
        divisor = 0;
        step(50);
        chk("t5_unused", r0 + r3 > 0, 1);

        // reset in the middle of byte 1
        push_tx(32'h11111111, 0);
        push_tx(32'h22222222, 0);
        step(220);
        reset = 1;
        step(1);
        chk("t6_tx", tx, 1);
        chk("t6_tx_empty", tx_empty, 1);
        chk("t6_tx_full", tx_full, 0);
        chk("t6_rx_empty", rx_empty, 1);
        chk("t6_r_data", r_data, 0);
        chk("t6_flags", {frame_err, overrun, parity_err}, 0);
        reset = 0;
        step(40);
        chk("t6_idle_after", {tx, rx_empty, frame_err}, 3'b110);
        push_tx(32'hA5A5A5A5, 1);
        pop_rx("t6_rx");
        step(1);
        chk("t6_rx_empty_end", rx_empty, 1);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
